// File: rtl/aes_key_expand.sv
// AES-128 key schedule: latches a cipher key and streams round keys 0..NR over valid/ready.
// Optional build macro KEYEXP_STORE_EN adds an 11-entry round-key store read through rd_idx/rd_key.
`ifndef W_KEY
`define W_KEY 128
`endif

module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [`W_KEY-1:0] key_in,
    input  logic              start,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [`W_KEY-1:0] rk_out,
    output logic [3:0]        rk_round,
    output logic              done
`ifdef KEYEXP_STORE_EN
    ,
    input  logic [3:0]        rd_idx,
    output logic [`W_KEY-1:0] rd_key
`endif
);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t            state_q, state_d;
    logic [`W_KEY-1:0] rk_q, rk_d;
    logic [3:0]        round_q, round_d;
    logic              done_q, done_d;

    logic              xfer;
    logic              last;
    logic [7:0]        rcon;
    logic [31:0]       w0, w1, w2, w3;
    logic [31:0]       rot, t;
    logic [31:0]       n0, n1, n2, n3;

    always_comb begin
        case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Next round key from the current one: RotWord, SubWord, Rcon, then the XOR chain.
    assign w0  = rk_q[127:96];
    assign w1  = rk_q[95:64];
    assign w2  = rk_q[63:32];
    assign w3  = rk_q[31:0];
    assign rot = {w3[23:0], w3[31:24]};
    assign t   = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
               ^ {rcon, 24'h000000};
    assign n0  = w0 ^ t;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    assign xfer = (state_q == S_EMIT) && rk_ready;
    assign last = (round_q == 4'(NR));

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rk_d    = key_in;
                    round_d = 4'd0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (xfer) begin
                    if (last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rk_d    = {n0, n1, n2, n3};
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rk_q    <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == S_EMIT);
    assign rk_valid = (state_q == S_EMIT);
    assign rk_out   = rk_q;
    assign rk_round = round_q;
    assign done     = done_q;

`ifdef KEYEXP_STORE_EN
    // Entries persist across runs; only reset clears them, a new run overwrites as it streams.
    logic [`W_KEY-1:0] store_q [NR+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                store_q[i] <= '0;
            end
        end else if (xfer) begin
            store_q[round_q] <= rk_q;
        end
    end

    assign rd_key = (rd_idx <= 4'(NR)) ? store_q[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Testbench for aes_key_expand: random keys and backpressure checked against a word-level
// FIPS-197 key schedule model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_expand;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         start;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;
`ifdef KEYEXP_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    int           n_total = 0;
    int           n_bad   = 0;
    logic [7:0]   sbox_m [256];
    logic [7:0]   rcon_m [10];
    logic [127:0] exp_rk [11];
    logic [127:0] seen   [11];

    aes_key_expand dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .start    (start),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .done     (done)
`ifdef KEYEXP_STORE_EN
        ,
        .rd_idx   (rd_idx),
        .rd_key   (rd_key)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] r;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        r = 8'h01;
        for (int i = 0; i < 10; i++) begin
            rcon_m[i] = r;
            r = xt(r);
        end
    endtask

    task automatic build_sched(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
                    ^ {rcon_m[i/4-1], 24'h000000};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called on a negedge; start is driven at once so a call right after a done check is back-to-back.
    task automatic run_stream(input logic [127:0] key, input int pct,
                              input logic [127:0] alt_key, input int alt_at, output int cyc);
        int  r;
        logic go;
        build_sched(key);
        start    = 1'b1;
        key_in   = key;
        rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("done_low_after_start", 128'(done), 128'(1'b0));
        r   = 0;
        cyc = 0;
        while (r <= NR && cyc < 400) begin
            chk("valid", 128'(rk_valid), 128'(1'b1));
            chk("busy", 128'(busy), 128'(1'b1));
            chk("round", 128'(rk_round), 128'(r));
            chk("rk", rk_out, exp_rk[r]);
            seen[r] = rk_out;
            if (r == alt_at) begin
                start  = 1'b1;
                key_in = alt_key;
            end else begin
                start  = 1'b0;
                key_in = rnd128();
            end
            go       = ($urandom_range(99) < 32'(pct));
            rk_ready = go;
            @(negedge clk);
            cyc++;
            if (go) r++;
        end
        chk("stream_in_budget", 128'(r), 128'(NR + 1));
        start    = 1'b0;
        rk_ready = 1'b0;
        chk("done_pulse", 128'(done), 128'(1'b1));
        chk("valid_after_last", 128'(rk_valid), 128'(1'b0));
        chk("busy_after_last", 128'(busy), 128'(1'b0));
    endtask

    initial begin
        int          cyc;
        logic [127:0] k1, k2, kr;
        k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        k2 = 128'h000102030405060708090a0b0c0d0e0f;
        build_tables();

        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
`ifdef KEYEXP_STORE_EN
        rd_idx   = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_valid", 128'(rk_valid), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_rk", rk_out, 128'h0);
        chk("rst_round", 128'(rk_round), 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 vector, continuous ready
        run_stream(k1, 100, '0, -1, cyc);
        chk("fips_r0", seen[0], k1);
        chk("fips_r1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_cycles", 128'(cyc), 128'(11));
`ifdef KEYEXP_STORE_EN
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            chk($sformatf("store_%0d", i), rd_key, (i <= NR) ? exp_rk[i] : 128'h0);
        end
`endif
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'(1'b0));

        // backpressure on the FIPS key, then random keys
        run_stream(k1, 50, '0, -1, cyc);
        chk("bp_r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            kr = rnd128();
            run_stream(kr, 40 + 15 * n, '0, -1, cyc);
        end

        // start mid-stream is ignored; the next run uses the new key
        @(negedge clk);
        run_stream(k1, 70, k2, 4, cyc);
        @(negedge clk);
        run_stream(k2, 100, '0, -1, cyc);
        chk("k2_r10", seen[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // asynchronous reset mid-stream at r=6
        @(negedge clk);
        start  = 1'b1;
        key_in = k1;
        @(negedge clk);
        start    = 1'b0;
        rk_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_rst_round", 128'(rk_round), 128'(6));
        rk_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(rk_valid), 128'(1'b0));
        chk("arst_busy", 128'(busy), 128'(1'b0));
        chk("arst_rk", rk_out, 128'h0);
        chk("arst_round", 128'(rk_round), 128'h0);
`ifdef KEYEXP_STORE_EN
        rd_idx = 4'd1;
        #1;
        chk("arst_store", rd_key, 128'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 128'(rk_valid), 128'(1'b0));
        kr = rnd128();
        run_stream(kr, 80, '0, -1, cyc);

        // back-to-back: start issued in the done cycle
        @(negedge clk);
        kr = rnd128();
        run_stream(kr, 100, '0, -1, cyc);
        run_stream(k1, 100, '0, -1, cyc);
        chk("b2b_r10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("b2b_cycles", 128'(cyc), 128'(11));
        @(negedge clk);
        chk("b2b_done_end", 128'(done), 128'(1'b0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
